// File: rtl/qr_sched_pkg.sv
// ============================================================================
// Module   : qr_sched_pkg
// Purpose  : Shared state encoding, output flag codes and entry width helper
//            for the QR batch scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package qr_sched_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_NEXT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [1:0] FLAG_DATA = 2'b00;
    localparam logic [1:0] FLAG_EOJ  = 2'b01;
    localparam logic [1:0] FLAG_TMO  = 2'b11;

    // Flag (2) plus payload byte (8); the job index width is added per instance.
    localparam int ENTRY_FIX_W = 10;

    function automatic int entry_w(input int job_w);
        return ENTRY_FIX_W + job_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qr_sched_fifo.sv
// ============================================================================
// Module   : qr_sched_fifo
// Purpose  : Synchronous FIFO with a registered head (first-word fall-through,
//            one cycle latency) and a drop indication when pushed while full.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qr_sched_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_drop
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr;
    logic [c_PW-1:0]  r_rd;
    logic [c_CW-1:0]  r_count;
    logic             r_valid;
    logic [WIDTH-1:0] r_head;

    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic [c_PW-1:0]  w_rd_nxt;
    logic [c_CW-1:0]  w_cnt_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    assign w_full    = (r_count == c_CW'(DEPTH));
    assign w_pop_ok  = i_pop && (r_count != '0);
    assign w_push_ok = i_push && (!w_full || w_pop_ok);
    assign w_rd_nxt  = r_rd + c_PW'(w_pop_ok);
    assign w_cnt_nxt = r_count + c_CW'(w_push_ok) - c_CW'(w_pop_ok);

    // The new head may be the word being written this cycle (bypass).
    always_comb begin
        w_head_nxt = '0;
        if (w_cnt_nxt != '0) begin
            if (w_push_ok && (w_rd_nxt == r_wr)) begin
                w_head_nxt = i_wdata;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_head  <= '0;
        end else begin
            r_wr    <= r_wr + c_PW'(w_push_ok);
            r_rd    <= w_rd_nxt;
            r_count <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != '0);
            r_head  <= w_head_nxt;
        end
    end

    assign o_full  = w_full;
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_valid = r_valid;
    assign o_rdata = r_head;
    assign o_drop  = i_push && w_full && !w_pop_ok;

endmodule

`default_nettype wire

// File: rtl/qr_batch_sched.sv
// ============================================================================
// Module   : qr_batch_sched
// Purpose  : Runs the QR decoder over a batch of images, prefixes its SRAM
//            address with the image index and queues bytes plus per-image
//            trailers. Optional watchdog: define QR_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qr_batch_sched
    import qr_sched_pkg::*;
#(
    parameter int IMG_AW      = 12,
    parameter int JOB_W       = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    batch_start,
    input  logic [JOB_W-1:0]        batch_num,
    output logic                    dec_start,
    input  logic [IMG_AW-1:0]       dec_raddr,
    input  logic                    dec_valid,
    input  logic [7:0]              dec_code,
    input  logic                    dec_finish,
    output logic [IMG_AW+JOB_W-1:0] sram_raddr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic [JOB_W-1:0]        out_job,
    output logic [1:0]              out_flag,
    output logic                    batch_busy,
    output logic                    batch_done,
    output logic                    overflow
);

    localparam int c_EW = entry_w(JOB_W);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [JOB_W-1:0] r_job;
    logic [JOB_W-1:0] r_num;
    logic [7:0]       r_bcnt;
    logic             r_ovf;

    logic             w_last;
    logic             w_timeout;
    logic             w_abort;
    logic [1:0]       w_trl_flag;
    logic             w_push;
    logic [c_EW-1:0]  w_wdata;
    logic [c_EW-1:0]  w_head;
    logic             w_drop;

    logic                        w_unused_full;
    logic                        w_unused_empty;
    logic [$clog2(FIFO_DEPTH):0] w_unused_count;

`ifdef QR_WATCHDOG_EN
    logic [15:0] r_wdog;
    logic        r_tmo;

    // A finish in the limit cycle wins over the timeout.
    assign w_timeout  = (r_state == ST_WAIT) && !dec_finish && (r_wdog == 16'(WDOG_CYCLES));
    assign w_abort    = r_tmo;
    assign w_trl_flag = r_tmo ? FLAG_TMO : FLAG_EOJ;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wdog <= '0;
            r_tmo  <= 1'b0;
        end else if (r_state == ST_LAUNCH) begin
            r_wdog <= '0;
            r_tmo  <= 1'b0;
        end else if (r_state == ST_WAIT) begin
            if (r_wdog != 16'(WDOG_CYCLES)) begin
                r_wdog <= r_wdog + 16'd1;
            end
            if (w_timeout) begin
                r_tmo <= 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_timeout    = 1'b0;
    assign w_abort      = 1'b0;
    assign w_trl_flag   = FLAG_EOJ;
    assign w_unused_cfg = ^{WDOG_CYCLES, FLAG_TMO};
`endif

    assign w_last = (r_job == (r_num - JOB_W'(1)));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (batch_start) begin
                    w_state_nxt = (batch_num != '0) ? ST_LAUNCH : ST_DONE;
                end
            end
            ST_LAUNCH: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (dec_finish || w_timeout) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT:   w_state_nxt = (w_last || w_abort) ? ST_DONE : ST_LAUNCH;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= ST_IDLE;
            r_job   <= '0;
            r_num   <= '0;
            r_bcnt  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (batch_start && (batch_num != '0)) begin
                        r_num  <= batch_num;
                        r_job  <= '0;
                        r_bcnt <= '0;
                        r_ovf  <= 1'b0;
                    end
                end
                ST_LAUNCH: r_bcnt <= '0;
                ST_WAIT: begin
                    if (dec_valid && (r_bcnt != 8'hFF)) begin
                        r_bcnt <= r_bcnt + 8'd1;
                    end
                end
                ST_NEXT: begin
                    if (w_state_nxt == ST_LAUNCH) begin
                        r_job <= r_job + JOB_W'(1);
                    end
                end
                default: ;
            endcase
            // Pushes only happen in WAIT/NEXT, so this never races the clear above.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign w_push  = ((r_state == ST_WAIT) && dec_valid) || (r_state == ST_NEXT);
    assign w_wdata = (r_state == ST_WAIT) ? {FLAG_DATA, r_job, dec_code}
                                          : {w_trl_flag, r_job, r_bcnt};

    qr_sched_fifo #(
        .WIDTH (c_EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (srst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (out_valid && out_ready),
        .o_full  (w_unused_full),
        .o_empty (w_unused_empty),
        .o_count (w_unused_count),
        .o_valid (out_valid),
        .o_rdata (w_head),
        .o_drop  (w_drop)
    );

    assign out_flag   = w_head[c_EW-1 -: 2];
    assign out_job    = w_head[8 +: JOB_W];
    assign out_data   = w_head[7:0];
    assign sram_raddr = {r_job, dec_raddr};
    assign dec_start  = (r_state == ST_LAUNCH);
    assign batch_done = (r_state == ST_DONE);
    assign batch_busy = (r_state != ST_IDLE);
    assign overflow   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_qr_batch_sched.sv
// ============================================================================
// Module   : tb_qr_batch_sched
// Purpose  : Self-checking bench for qr_batch_sched with a queue-based FIFO
//            model and randomized decoder / consumer behaviour.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qr_batch_sched;

`ifdef QR_WATCHDOG_EN
    localparam int TB_WDOG = 100;
`else
    localparam int TB_WDOG = 65535;
`endif

    logic        clk;
    logic        srst;
    logic        batch_start;
    logic [3:0]  batch_num;
    logic        dec_start;
    logic [11:0] dec_raddr;
    logic        dec_valid;
    logic [7:0]  dec_code;
    logic        dec_finish;
    logic [15:0] sram_raddr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [3:0]  out_job;
    logic [1:0]  out_flag;
    logic        batch_busy;
    logic        batch_done;
    logic        overflow;

    qr_batch_sched #(
        .IMG_AW      (12),
        .JOB_W       (4),
        .FIFO_DEPTH  (16),
        .WDOG_CYCLES (TB_WDOG)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .batch_start (batch_start),
        .batch_num   (batch_num),
        .dec_start   (dec_start),
        .dec_raddr   (dec_raddr),
        .dec_valid   (dec_valid),
        .dec_code    (dec_code),
        .dec_finish  (dec_finish),
        .sram_raddr  (sram_raddr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_job     (out_job),
        .out_flag    (out_flag),
        .batch_busy  (batch_busy),
        .batch_done  (batch_done),
        .overflow    (overflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus-side knowledge shared with the model.
    bit         mon_en = 0;
    bit         tb_wait = 0;
    bit         tb_accept = 0;
    bit         tb_tmo_push = 0;
    logic [3:0] tb_job = '0;
    int         rdy_mode = 0;
    bit         addr_test = 0;

    int         img_n [16];
    bit         img_coin [16];
    logic [7:0] img_last [16];

    // Model: actual FIFO contents as a queue, plus sticky overflow.
    logic [13:0] m_fifo [$];
    bit          m_ovf = 0;
    int          m_bytes = 0;
    bit          m_trl_pend = 0;
    logic [3:0]  m_pend_job = '0;
    logic [7:0]  m_pend_cnt = '0;
    int          n_starts = 0;
    int          n_dut_pop = 0;
    bit          m_pop;
    bit          m_push;
    logic [13:0] m_ent;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] sat8(input int v);
        return (v > 255) ? 8'hFF : 8'(v);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom % 4 != 0);
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            m_cnt = m_fifo.size();
            chk("out_valid", 32'(out_valid), 32'(m_cnt > 0));
            if (m_cnt > 0) begin
                chk("head", 32'({out_flag, out_job, out_data}), 32'(m_fifo[0]));
            end
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (out_valid && out_ready) n_dut_pop++;
            if (dec_start) n_starts++;
            if (srst) begin
                m_fifo.delete();
                m_ovf = 0;
                m_bytes = 0;
                m_trl_pend = 0;
            end else begin
                m_pop  = (m_cnt > 0) && out_ready;
                m_push = 0;
                m_ent  = '0;
                if (m_pop) void'(m_fifo.pop_front());
                if (m_trl_pend) begin
                    m_push = 1;
                    m_ent  = {2'b01, m_pend_job, m_pend_cnt};
                end else if (tb_tmo_push) begin
                    m_push  = 1;
                    m_ent   = {2'b11, tb_job, sat8(m_bytes)};
                    m_bytes = 0;
                end else if (tb_wait && dec_valid) begin
                    m_push  = 1;
                    m_ent   = {2'b00, tb_job, dec_code};
                    m_bytes = m_bytes + 1;
                end
                m_trl_pend = 0;
                if (tb_wait && dec_finish) begin
                    m_trl_pend = 1;
                    m_pend_job = tb_job;
                    m_pend_cnt = sat8(m_bytes);
                    m_bytes    = 0;
                end
                if (m_push) begin
                    if (m_cnt < 16 || m_pop) m_fifo.push_back(m_ent);
                    else m_ovf = 1;
                end
                if (tb_accept) m_ovf = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_batch(input int num, input bit spur);
        cyc();
        batch_start = 1'b1;
        batch_num   = 4'(num);
        tb_accept   = (num != 0);
        @(negedge clk);
        cyc();
        batch_start = 1'b0;
        tb_accept   = 1'b0;
        @(negedge clk);
        if (num == 0) begin
            chk("zero_done", 32'(batch_done), 1);
            chk("zero_nostart", 32'(dec_start), 0);
            cyc();
            @(negedge clk);
            chk("zero_idle", 32'(batch_busy), 0);
            chk("zero_done_pulse", 32'(batch_done), 0);
            return;
        end
        chk("launch_first", 32'(dec_start), 1);
        chk("busy", 32'(batch_busy), 1);
        for (int j = 0; j < num; j++) begin
            int emitted;
            bit fin;
            int guard;
            emitted = 0;
            fin     = 0;
            guard   = 0;
            tb_job  = 4'(j);
            while (!fin && guard < 200) begin
                cyc();
                guard++;
                tb_wait     = 1'b1;
                batch_start = spur && (guard == 2);
                batch_num   = 4'hF;
                dec_raddr   = 12'($urandom);
                dec_code    = 8'($urandom);
                dec_valid   = 1'b0;
                dec_finish  = 1'b0;
                if (img_coin[j] && emitted == img_n[j] - 1) begin
                    dec_valid  = 1'b1;
                    dec_code   = img_last[j];
                    dec_finish = 1'b1;
                    emitted++;
                    fin = 1;
                end else if (!img_coin[j] && emitted == img_n[j] && ($urandom % 2 == 0)) begin
                    dec_finish = 1'b1;
                    fin = 1;
                end else if (emitted < img_n[j] && ($urandom % 3 != 0)) begin
                    dec_valid = 1'b1;
                    emitted++;
                end
                if (addr_test && j == 2) dec_raddr = 12'h0A5;
                @(negedge clk);
                chk("sram_raddr", 32'(sram_raddr), 32'({tb_job, dec_raddr}));
                if (addr_test && j == 2) chk("addr_prefix", 32'(sram_raddr), 32'h20A5);
                chk("no_start_in_wait", 32'(dec_start), 0);
            end
            chk("finish_reached", 32'(fin), 1);
            cyc();
            tb_wait     = 1'b0;
            batch_start = 1'b0;
            dec_finish  = 1'b0;
            dec_valid   = 1'($urandom);
            @(negedge clk);
            chk("next_nostart", 32'(dec_start), 0);
            chk("next_busy", 32'(batch_busy), 1);
            chk("next_nodone", 32'(batch_done), 0);
            cyc();
            dec_valid = 1'b0;
            @(negedge clk);
            if (j < num - 1) begin
                chk("relaunch", 32'(dec_start), 1);
            end else begin
                chk("done", 32'(batch_done), 1);
                chk("done_nostart", 32'(dec_start), 0);
            end
        end
        cyc();
        @(negedge clk);
        chk("idle_after", 32'(batch_busy), 0);
        chk("done_once", 32'(batch_done), 0);
    endtask

    task automatic drain();
        rdy_mode = 1;
        for (int i = 0; i < 80 && (out_valid || m_fifo.size() != 0); i++) begin
            @(negedge clk);
        end
        chk("drained", 32'(out_valid), 0);
    endtask

    initial begin
        int s0;
        int p0;
        srst        = 1'b1;
        batch_start = 1'b0;
        batch_num   = '0;
        dec_raddr   = 12'h123;
        dec_valid   = 1'b0;
        dec_code    = '0;
        dec_finish  = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_dec_start", 32'(dec_start), 0);
        chk("rst_busy", 32'(batch_busy), 0);
        chk("rst_done", 32'(batch_done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_out_word", 32'({out_flag, out_job, out_data}), 0);
        chk("rst_sram_raddr", 32'(sram_raddr), 32'h0123);
        mon_en = 1;
        cyc();
        srst = 1'b0;

        // Basic three-image batch with address prefix check in job 2.
        rdy_mode = 1;
        img_n[0] = 5; img_n[1] = 0; img_n[2] = 2;
        for (int j = 0; j < 3; j++) img_coin[j] = 0;
        s0 = n_starts;
        p0 = n_dut_pop;
        addr_test = 1;
        run_batch(3, 0);
        addr_test = 0;
        drain();
        chk("basic_starts", 32'(n_starts - s0), 3);
        chk("basic_entries", 32'(n_dut_pop - p0), 10);

        // Zero-length batch.
        s0 = n_starts;
        run_batch(0, 0);
        chk("zero_starts", 32'(n_starts - s0), 0);

        // Backpressure and overflow.
        rdy_mode = 0;
        cyc();
        img_n[0] = 20; img_coin[0] = 0;
        run_batch(1, 0);
        chk("ovf_set", 32'(overflow), 1);
        p0 = n_dut_pop;
        drain();
        chk("ovf_kept", 32'(n_dut_pop - p0), 16);
        img_n[0] = 0;
        run_batch(1, 0);
        chk("ovf_cleared", 32'(overflow), 0);

        // Coincident last byte and finish, with a stray batch_start while busy.
        s0 = n_starts;
        img_n[0] = 3; img_coin[0] = 1; img_last[0] = 8'h41;
        run_batch(1, 1);
        drain();
        chk("coin_starts", 32'(n_starts - s0), 1);

        // Randomized batches.
        for (int b = 0; b < 12; b++) begin
            int num;
            num = 1 + int'($urandom % 4);
            for (int j = 0; j < num; j++) begin
                img_n[j]    = int'($urandom % 8);
                img_coin[j] = (img_n[j] > 0) && ($urandom % 3 == 0);
                img_last[j] = 8'($urandom);
            end
            rdy_mode = 2;
            run_batch(num, (b % 3) == 0);
        end
        drain();

        // Reset in the middle of WAIT.
        rdy_mode = 0;
        cyc();
        cyc();
        batch_start = 1'b1;
        batch_num   = 4'd2;
        tb_accept   = 1'b1;
        cyc();
        batch_start = 1'b0;
        tb_accept   = 1'b0;
        cyc();
        tb_job    = 4'd0;
        tb_wait   = 1'b1;
        dec_valid = 1'b1;
        dec_code  = 8'h11;
        cyc();
        dec_code  = 8'h22;
        cyc();
        dec_valid = 1'b0;
        srst      = 1'b1;
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 1);
        cyc();
        srst    = 1'b0;
        tb_wait = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(batch_busy), 0);
        chk("midrst_addr", 32'(sram_raddr), 32'({4'h0, dec_raddr}));
        rdy_mode = 1;

`ifdef QR_WATCHDOG_EN
        // Watchdog: no finish on image 0 of 3; remaining images are skipped.
        s0 = n_starts;
        cyc();
        batch_start = 1'b1;
        batch_num   = 4'd3;
        tb_accept   = 1'b1;
        cyc();
        batch_start = 1'b0;
        tb_accept   = 1'b0;
        @(negedge clk);
        chk("wd_launch", 32'(dec_start), 1);
        tb_job = 4'd0;
        for (int k = 0; k <= 100; k++) begin
            cyc();
            tb_wait   = 1'b1;
            dec_valid = (k < 2);
            dec_code  = 8'(k + 1);
        end
        cyc();
        tb_wait     = 1'b0;
        dec_valid   = 1'b0;
        tb_tmo_push = 1'b1;
        @(negedge clk);
        chk("wd_next_nodone", 32'(batch_done), 0);
        cyc();
        tb_tmo_push = 1'b0;
        @(negedge clk);
        chk("wd_done", 32'(batch_done), 1);
        chk("wd_nostart", 32'(dec_start), 0);
        cyc();
        @(negedge clk);
        chk("wd_idle", 32'(batch_busy), 0);
        drain();
        chk("wd_skip", 32'(n_starts - s0), 1);
`endif

        cyc();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
